// File: rtl/nr_recip_iter_pkg.sv
// Shared types and constants for the Newton-Raphson reciprocal refinement stage.
// Fixed-point formats: divisor 1.15, reciprocal 1.16, products 2.31 / 2.32.
package nr_recip_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL_DX = 2'd1,
        MUL_XW = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int D_W    = 16;
    localparam int X_W    = 17;
    localparam int PROD_W = 34;

    localparam logic [17:0]    TWO_1P16 = 18'h20000;
    localparam logic [X_W-1:0] ONE_1P16 = 17'h10000;

    // Takes q[33:16] of the 2.32 product and clamps the 1.16 result at 1.0
    function automatic logic [X_W-1:0] sat_1p16(input logic [17:0] q_hi);
        logic [X_W-1:0] r;
        if (q_hi > {1'b0, ONE_1P16}) begin
            r = ONE_1P16;
        end else begin
            r = q_hi[16:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/nr_recip_iter_if.sv
// Start/done handshake and operand/result bus of the reciprocal refinement stage.
interface nr_recip_iter_if;
    import nr_recip_pkg::*;

    logic           start;
    logic [D_W-1:0] d_in;
    logic [7:0]     x0_in;
    logic           busy;
    logic           done;
    logic [X_W-1:0] recip_out;

    modport master (output start, d_in, x0_in, input busy, done, recip_out);
    modport slave  (input start, d_in, x0_in, output busy, done, recip_out);

endinterface

// File: rtl/nr_recip_iter_mul17x17.sv
// Unsigned 17x17 -> 34 combinational multiplier shared by both iteration steps.
module mul17x17
    import nr_recip_pkg::*;
(
    input  logic [X_W-1:0]    a,
    input  logic [X_W-1:0]    b,
    output logic [PROD_W-1:0] p
);

    // full-width unsigned product
    always_comb begin
        p = {17'd0, a} * {17'd0, b};
    end

endmodule

// File: rtl/nr_recip_iter.sv
// Newton-Raphson reciprocal refinement: ITERS rounds of x <- x*(2 - d*x) on one
// shared multiplier, two cycles per round, start/done handshake.
module nr_recip_iter
    import nr_recip_pkg::*;
#(
    parameter int ITERS = 2
) (
    input  logic           clk,
    input  logic           reset,
    nr_recip_iter_if.slave bus
);

    localparam logic [1:0] ITER_LAST = 2'(ITERS - 1);

    state_t         state_r;
    state_t         state_next_s;
    logic [D_W-1:0] d_r;
    logic [X_W-1:0] x_r;
    logic [X_W-1:0] w_r;
    logic [X_W-1:0] recip_r;
    logic [1:0]     iter_r;
    logic           busy_r;
    logic           done_r;

    logic              accept_s;
    logic              last_iter_s;
    logic [X_W-1:0]    mul_a_s;
    logic [X_W-1:0]    mul_b_s;
    logic [PROD_W-1:0] prod_s;
    logic [X_W-1:0]    w_calc_s;
    logic [X_W-1:0]    x_upd_s;
    logic              unused_bits_s;

    // next-state decode; a new start is taken in IDLE and in DONE (back-to-back)
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        last_iter_s  = (iter_r == ITER_LAST);
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept_s     = 1'b1;
                    state_next_s = MUL_DX;
                end else begin
                    state_next_s = IDLE;
                end
            end
            MUL_DX: state_next_s = MUL_XW;
            MUL_XW: begin
                if (last_iter_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = MUL_DX;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // multiplier operand mux: (d, x) while forming d*x, (x, w) while forming x*w
    always_comb begin
        if (state_r == MUL_XW) begin
            mul_a_s = x_r;
            mul_b_s = w_r;
        end else begin
            mul_a_s = {1'b0, d_r};
            mul_b_s = x_r;
        end
    end

    mul17x17 u_mul (
        .a (mul_a_s),
        .b (mul_b_s),
        .p (prod_s)
    );

    // w = 2 - d*x from the truncated 1.16 product; next x = x*w clamped at 1.0
    always_comb begin
        w_calc_s      = X_W'(TWO_1P16 - {1'b0, prod_s[31:15]});
        x_upd_s       = sat_1p16(prod_s[33:16]);
        unused_bits_s = ^{bus.x0_in[7], prod_s[14:0]};
    end

    // state register with registered busy/done decoded from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == MUL_DX) || (state_next_s == MUL_XW);
            done_r  <= (state_next_s == DONE);
        end
    end

    // operand latch and iteration datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            d_r     <= 16'h0000;
            x_r     <= 17'h00000;
            w_r     <= 17'h00000;
            recip_r <= 17'h00000;
            iter_r  <= 2'd0;
        end else if (accept_s) begin
            d_r    <= bus.d_in;
            x_r    <= {1'b0, 1'b1, bus.x0_in[6:0], 8'h00};
            iter_r <= 2'd0;
        end else if (state_r == MUL_DX) begin
            w_r <= w_calc_s;
        end else if (state_r == MUL_XW) begin
            x_r     <= x_upd_s;
            recip_r <= x_upd_s;
            if (!last_iter_s) begin
                iter_r <= iter_r + 2'd1;
            end
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.recip_out = recip_r;

endmodule

// File: tb/tb_nr_recip_iter.sv
// Directed self-checking bench: three instances (ITERS=1,2,3) driven with the same operands.
module tb_nr_recip_iter;
    import nr_recip_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] d_in;
    logic [7:0]  x0_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [16:0] res [3];
    int          done_cyc [3];
    int          busy_cnt [3];
    int          done_cnt [3];

    nr_recip_iter_if bus1 ();
    nr_recip_iter_if bus2 ();
    nr_recip_iter_if bus3 ();

    assign bus1.start = start;
    assign bus1.d_in  = d_in;
    assign bus1.x0_in = x0_in;
    assign bus2.start = start;
    assign bus2.d_in  = d_in;
    assign bus2.x0_in = x0_in;
    assign bus3.start = start;
    assign bus3.d_in  = d_in;
    assign bus3.x0_in = x0_in;

    nr_recip_iter #(.ITERS(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
    nr_recip_iter #(.ITERS(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));
    nr_recip_iter #(.ITERS(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // bit-level reference of the refinement arithmetic
    function automatic logic [16:0] model_recip(input logic [15:0] d, input logic [7:0] x0, input int iters);
        logic [16:0] x;
        logic [16:0] w;
        logic [33:0] p;
        logic [33:0] q;
        logic [17:0] diff;
        x = {1'b0, 1'b1, x0[6:0], 8'h00};
        for (int i = 0; i < iters; i++) begin
            p    = {18'd0, d} * {17'd0, x};
            diff = 18'h20000 - {1'b0, p[31:15]};
            w    = diff[16:0];
            q    = {17'd0, x} * {17'd0, w};
            if (q[33:16] > 18'h10000) x = 17'h10000;
            else                       x = q[32:16];
        end
        return x;
    endfunction

    task automatic note(input int j, input int c, input logic b, input logic dn, input logic [16:0] r);
        if (b) busy_cnt[j]++;
        if (dn) begin
            done_cnt[j]++;
            if (done_cyc[j] == 0) begin
                done_cyc[j] = c;
                res[j]      = r;
            end
        end
    endtask

    // one transaction from idle; cycle c is the cycle after accept edge + (c-1)
    task automatic do_op(input logic [15:0] d, input logic [7:0] x0);
        for (int j = 0; j < 3; j++) begin
            res[j] = 17'h00000; done_cyc[j] = 0; busy_cnt[j] = 0; done_cnt[j] = 0;
        end
        @(posedge clk); #1;
        start = 1'b1; d_in = d; x0_in = x0;
        @(posedge clk); #1;
        start = 1'b0; d_in = ~d; x0_in = ~x0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            note(0, c, bus1.busy, bus1.done, bus1.recip_out);
            note(1, c, bus2.busy, bus2.done, bus2.recip_out);
            note(2, c, bus3.busy, bus3.done, bus3.recip_out);
        end
    endtask

    task automatic check_op(input string tag, input logic [15:0] d, input logic [7:0] x0);
        do_op(d, x0);
        for (int j = 0; j < 3; j++) begin
            check_val($sformatf("%s_res_i%0d", tag, j + 1), {15'd0, res[j]}, {15'd0, model_recip(d, x0, j + 1)});
            check_val($sformatf("%s_donecyc_i%0d", tag, j + 1), done_cyc[j], 2 * (j + 1) + 1);
            check_val($sformatf("%s_busy_i%0d", tag, j + 1), busy_cnt[j], 2 * (j + 1));
            check_val($sformatf("%s_ndone_i%0d", tag, j + 1), done_cnt[j], 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          first_done;
        int          second_done;
        int          ndone;
        logic        busy6;
        logic [16:0] ra;
        logic [16:0] rb;
        logic [15:0] d;
        logic [7:0]  x0;
        longint      ref_v;
        longint      err;

        reset = 1'b1; start = 1'b0; d_in = 16'h0000; x0_in = 8'h00;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_val("rst_busy", bus2.busy, 0);
        check_val("rst_done", bus2.done, 0);
        check_val("rst_recip", bus2.recip_out, 0);

        // unity divisor: x0=0.99609375 -> 0x0FFFF after the first round
        check_op("unity", 16'h8000, 8'h7F);
        check_val("unity_iter1", res[0], 17'h0FFFF);
        check_val("unity_final", res[1], 17'h0FFFF);
        check_val("unity_donecyc", done_cyc[1], 5);

        // d = 1.5: 0xAB00 -> 0xAAAA -> 0xAAAA
        check_op("d1p5", 16'hC000, 8'h2B);
        check_val("d1p5_iter1", res[0], 17'h0AAAA);
        check_val("d1p5_final", res[1], 17'h0AAAA);
        check_val("d1p5_busy4", busy_cnt[1], 4);

        // reset in the middle of an operation
        @(posedge clk); #1;
        start = 1'b1; d_in = 16'hA000; x0_in = 8'h4C;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check_val("midrst_busy_before", bus2.busy, 1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_val("midrst_busy", bus2.busy, 0);
        check_val("midrst_done", bus2.done, 0);
        check_val("midrst_recip", bus2.recip_out, 0);
        check_val("midrst_recip3", bus3.recip_out, 0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus2.done || bus3.done) ndone++;
        end
        check_val("midrst_nodone", ndone, 0);

        // start held for 6 cycles; operands change while busy
        first_done = 0; second_done = 0; busy6 = 1'b0; ra = 17'h00000; rb = 17'h00000;
        @(posedge clk); #1;
        start = 1'b1; d_in = 16'hC000; x0_in = 8'h2B;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c <= 4) begin
                d_in  = 16'h9000 + 16'(c) * 16'h0123;
                x0_in = 8'h11 * 8'(c);
            end else if (c == 5) begin
                d_in = 16'hA000; x0_in = 8'h4C;
            end else begin
                start = 1'b0; d_in = 16'hFFFF; x0_in = 8'h00;
            end
            @(negedge clk);
            if (c == 6) busy6 = bus2.busy;
            if (bus2.done) begin
                if (first_done == 0) begin
                    first_done = c; ra = bus2.recip_out;
                end else if (second_done == 0) begin
                    second_done = c; rb = bus2.recip_out;
                end
            end
        end
        check_val("hs_first_done", first_done, 5);
        check_val("hs_first_res", ra, 17'h0AAAA);
        check_val("hs_b2b_busy", busy6, 1);
        check_val("hs_second_done", second_done, 10);
        check_val("hs_second_res", rb, 17'h0CCCC);
        check_val("hs_second_model", rb, model_recip(16'hA000, 8'h4C, 2));

        // d = 0.5 pushes x*w above 1.0 in every round
        check_op("sat", 16'h4000, 8'h7F);
        check_val("sat_i1", res[0], 17'h10000);
        check_val("sat_i2", res[1], 17'h10000);
        check_val("sat_i3", res[2], 17'h10000);
        check_op("d8001", 16'h8001, 8'h7F);
        check_val("d8001_i1", res[0], 17'h0FFFE);
        check_val("d8001_le1", res[1] <= 17'h10000, 1);

        // sweep every table index with a truncated-reciprocal seed
        for (int i = 0; i < 128; i++) begin
            d     = {1'b1, 7'(i), 8'h80};
            ref_v = 64'h8000_0000 / longint'(d);
            x0    = 8'(ref_v >> 8);
            check_op($sformatf("sweep%0d", i), d, x0);
            for (int j = 1; j < 3; j++) begin
                err = (longint'(res[j]) > ref_v) ? longint'(res[j]) - ref_v : ref_v - longint'(res[j]);
                check_val($sformatf("sweep%0d_err_i%0d", i, j + 1), err <= 3, 1);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
